arm_main_decoder: RTL and testbench
===================================

Name: arm_main_decoder

Overview:
- Main control decoder of the single-cycle ARM-subset processor's control unit.
- Decodes instruction Op[1:0] together with Funct bit 5 (I, immediate flag) and Funct bit 0 (S/L, load flag) into the datapath control strobes.
- Outputs are registered: the decode of the current inputs appears one clock later.
- Feeds the ALU decoder (ALUOp), the register file, the memory interface and the PC logic (Branch).

Parameters:
- None. Widths are fixed by the ISA subset.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous reset, active-low
- Op  input  2  instruction bits [27:26]
- Funct5  input  1  instruction bit 25 (immediate operand select)
- Funct0  input  1  instruction bit 20 (L bit, load vs store)
- Branch  output  1  branch instruction
- MemtoReg  output  1  write-back source is data memory
- MemW  output  1  data memory write enable
- ALUSrc  output  1  ALU operand B is extended immediate
- ImmSrc  output  2  extend-unit mode: 00 = imm8, 01 = imm12, 10 = imm24 branch
- RegW  output  1  register file write enable
- RegSrc  output  2  bit0 = Rn is R15 (PC), bit1 = Rm field comes from Rd (store)
- ALUOp  output  1  ALU decoder must examine Funct (data-processing instruction)

Behaviour:
- One clock, asynchronous active-low reset. While rst_n = 0, all outputs are forced to 0 immediately, independent of clk. This all-zero word is a NOP.
- On each rising clk edge with rst_n = 1, every output loads the combinational decode of the Op, Funct5 and Funct0 values sampled at that edge. Latency is exactly 1 cycle; there is no handshake or stall.
- The decode table has no don't-cares; all outputs are fully specified. Fields listed are Branch, MemtoReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp.
  - Op=00, Funct5=0 (data-processing, register): 0,0,0,0,00,1,00,1
  - Op=00, Funct5=1 (data-processing, immediate): 0,0,0,1,00,1,00,1
  - Op=01, Funct0=0 (STR): 0,0,1,1,01,0,10,0
  - Op=01, Funct0=1 (LDR): 0,1,0,1,01,1,00,0
  - Op=10 (B): 1,0,0,1,10,0,01,0
  - Op=11 (unsupported): all zeros, i.e. NOP with no register or memory write.
- Funct0 is ignored when Op is not 01. Funct5 is ignored when Op is not 00.
- Reset deasserting coincident with a clk edge: the first load occurs at the next clean edge. Outputs stay 0 until that edge.
- Reset asserted mid-stream: outputs go to 0 at once. Any pending decode is discarded.

Optional Feature:
- Macro: MAIN_DEC_ILLEGAL_OP_EN.
- Defined: adds output port IllegalOp (1 bit).
  - Registered with the same 1-cycle latency as the other outputs; reset value 0.
  - Asserted for one cycle per sampled Op=11. Other outputs still follow the NOP row.
- Undefined: the port does not exist. Op=11 decodes silently to NOP.

Decomposition:
- Package main_dec_pkg holds:
  - Op encodings: OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10.
  - ImmSrc encodings: IMM_8=2'b00, IMM_12=2'b01, IMM_24=2'b10.
  - Packed struct ctrl_t containing all control outputs.
  - Constant CTRL_NOP, all zeros.
- One sub-module, main_dec_logic: purely combinational, maps Op/Funct5/Funct0 to ctrl_t.
- The top level instantiates main_dec_logic, registers its ctrl_t output with async reset to CTRL_NOP, and unpacks it to the output ports.

Test Plan:
- Hold rst_n=0 with Op=00, Funct5=1 → all outputs 0. Release rst_n and clock one edge → ALUSrc=1, RegW=1, ALUOp=1, ImmSrc=00, RegSrc=00; all other outputs 0.
- Op=00, Funct5=0, clock one edge → RegW=1, ALUOp=1; all other outputs 0. Before the edge, outputs still show the previous decode, confirming 1-cycle latency.
- Op=01, Funct0=0, edge → MemW=1, ALUSrc=1, ImmSrc=01, RegSrc=10, RegW=0, MemtoReg=0. Then Funct0=1, edge → MemtoReg=1, RegW=1, ALUSrc=1, ImmSrc=01, RegSrc=00, MemW=0.
- Op=10 with Funct0 and Funct5 toggled across all four combinations, one edge each → every cycle shows Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, RegW=0, MemW=0.
- Op=11, edge → all outputs 0. With MAIN_DEC_ILLEGAL_OP_EN defined, IllegalOp=1 for that cycle, then 0 after Op=00 is applied.
- Pulse rst_n low between clk edges while decoding LDR → outputs drop to 0 without waiting for clk, and stay 0 until the first edge after release.

Source files
------------

// File: rtl/main_dec_pkg.sv
// Shared encodings and the packed control word for the ARM main decoder.
// MAIN_DEC_ILLEGAL_OP_EN adds an illegal_op flag to the control word.
package main_dec_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

`ifdef MAIN_DEC_ILLEGAL_OP_EN
    localparam int CTRL_W = 11;
`else
    localparam int CTRL_W = 10;
`endif

    typedef struct packed {
`ifdef MAIN_DEC_ILLEGAL_OP_EN
        logic       illegal_op;
`endif
        logic       branch;
        logic       mem_to_reg;
        logic       mem_w;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       reg_w;
        logic [1:0] reg_src;
        logic       alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/main_dec_logic.sv
// Combinational decode of Op/Funct5/Funct0 into the datapath control word.
// MAIN_DEC_ILLEGAL_OP_EN flags Op=11 in the control word.
module main_dec_logic
    import main_dec_pkg::*;
(
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    output ctrl_t      ctrl
);

    // Decode table; unused funct bits are deliberately ignored per opcode class
    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_DP: begin
                ctrl.reg_w   = 1'b1;
                ctrl.alu_op  = 1'b1;
                ctrl.imm_src = IMM_8;
                if (funct5) begin
                    ctrl.alu_src = 1'b1;
                end else begin
                    ctrl.alu_src = 1'b0;
                end
            end
            OP_MEM: begin
                ctrl.alu_src = 1'b1;
                ctrl.imm_src = IMM_12;
                if (funct0) begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_w      = 1'b1;
                end else begin
                    // store reads the data register through the Rm port
                    ctrl.mem_w   = 1'b1;
                    ctrl.reg_src = 2'b10;
                end
            end
            OP_BR: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.imm_src = IMM_24;
                ctrl.reg_src = 2'b01;
            end
            default: begin
                ctrl = CTRL_NOP;
`ifdef MAIN_DEC_ILLEGAL_OP_EN
                ctrl.illegal_op = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/arm_main_decoder.sv
// Registered main control decoder: outputs follow the inputs with one cycle latency.
// MAIN_DEC_ILLEGAL_OP_EN adds the IllegalOp output.
module arm_main_decoder
    import main_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic       Funct5,
    input  logic       Funct0,
    output logic       Branch,
    output logic       MemtoReg,
    output logic       MemW,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic       RegW,
    output logic [1:0] RegSrc,
`ifdef MAIN_DEC_ILLEGAL_OP_EN
    output logic       IllegalOp,
`endif
    output logic       ALUOp
);

    ctrl_t ctrl_s;
    ctrl_t ctrl_r;

    main_dec_logic u_logic (
        .op     (Op),
        .funct5 (Funct5),
        .funct0 (Funct0),
        .ctrl   (ctrl_s)
    );

    // Control word register; reset value is the NOP word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= CTRL_NOP;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign Branch   = ctrl_r.branch;
    assign MemtoReg = ctrl_r.mem_to_reg;
    assign MemW     = ctrl_r.mem_w;
    assign ALUSrc   = ctrl_r.alu_src;
    assign ImmSrc   = ctrl_r.imm_src;
    assign RegW     = ctrl_r.reg_w;
    assign RegSrc   = ctrl_r.reg_src;
    assign ALUOp    = ctrl_r.alu_op;
`ifdef MAIN_DEC_ILLEGAL_OP_EN
    assign IllegalOp = ctrl_r.illegal_op;
`endif

endmodule

// File: tb/tb_arm_main_decoder.sv
// Scoreboard bench for arm_main_decoder: driver pushes model results, monitor pops and compares.
// Build with MAIN_DEC_ILLEGAL_OP_EN to cover the IllegalOp output.
module tb_arm_main_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] Op;
    logic       Funct5;
    logic       Funct0;
    logic       Branch, MemtoReg, MemW, ALUSrc, RegW, ALUOp;
    logic [1:0] ImmSrc, RegSrc;
    logic       ill;

    int total = 0;
    int bad   = 0;

    // {ill, Branch, MemtoReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp}
    logic [10:0] act;
    logic [10:0] exp_q[$];
    logic [10:0] prev_exp;

    always #5 clk = ~clk;

    arm_main_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Op       (Op),
        .Funct5   (Funct5),
        .Funct0   (Funct0),
        .Branch   (Branch),
        .MemtoReg (MemtoReg),
        .MemW     (MemW),
        .ALUSrc   (ALUSrc),
        .ImmSrc   (ImmSrc),
        .RegW     (RegW),
        .RegSrc   (RegSrc),
`ifdef MAIN_DEC_ILLEGAL_OP_EN
        .IllegalOp(ill),
`endif
        .ALUOp    (ALUOp)
    );

`ifndef MAIN_DEC_ILLEGAL_OP_EN
    assign ill = 1'b0;
`endif

    assign act = {ill, Branch, MemtoReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp};

    // Reference model: classify the instruction, then derive each strobe from its meaning
    function automatic logic [10:0] model(input logic [1:0] op, input logic f5, input logic f0);
        logic is_dp, is_str, is_ldr, is_b, is_ill;
        logic [1:0] imm;
        logic il;
        is_dp  = (op == 2'd0);
        is_str = (op == 2'd1) && !f0;
        is_ldr = (op == 2'd1) && f0;
        is_b   = (op == 2'd2);
        is_ill = (op == 2'd3);
        imm    = is_b ? 2'd2 : ((is_str || is_ldr) ? 2'd1 : 2'd0);
`ifdef MAIN_DEC_ILLEGAL_OP_EN
        il = is_ill;
`else
        il = 1'b0;
        if (is_ill) il = 1'b0;
`endif
        return {il, is_b, is_ldr, is_str, (is_dp && f5) || is_str || is_ldr || is_b,
                imm, is_dp || is_ldr, is_str, is_b, is_dp};
    endfunction

    task automatic check(input string name, input logic [10:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    // Issue one decode: confirm outputs still hold the previous decode, then drive and predict
    task automatic step(input logic [1:0] op, input logic f5, input logic f0);
        @(negedge clk);
        check("hold_prev", prev_exp);
        Op = op;
        Funct5 = f5;
        Funct0 = f0;
        prev_exp = model(op, f5, f0);
        exp_q.push_back(prev_exp);
    endtask

    // Monitor: compare the registered outputs just after each edge against the oldest prediction
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("decode", e);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        Op = 2'b00;
        Funct5 = 1'b1;
        Funct0 = 1'b0;
        prev_exp = 11'd0;
        #2;
        check("reset_async", 11'd0);
        @(negedge clk);
        check("reset_hold", 11'd0);
        @(posedge clk);
        #1;
        check("reset_edge", 11'd0);

        // release away from an edge; DP immediate is loaded at the next edge
        @(negedge clk);
        rst_n = 1'b1;
        check("release", 11'd0);
        prev_exp = model(2'b00, 1'b1, 1'b0);
        exp_q.push_back(prev_exp);

        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(2'b10, i[0], i[1]);
        end
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b1);
        step(2'b11, 1'b0, 1'b1);

        // reset pulse between edges while LDR is registered
        step(2'b01, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", 11'd0);
        prev_exp = 11'd0;
        @(posedge clk);
        #1;
        check("mid_reset_edge", 11'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("after_release", 11'd0);
        @(negedge clk);
        check("before_first_edge", 11'd0);
        prev_exp = model(2'b01, 1'b0, 1'b1);
        exp_q.push_back(prev_exp);

        for (int i = 0; i < 200; i++) begin
            step(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        @(negedge clk);
        check("hold_last", prev_exp);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
